// File: rtl/reg_pkg.sv
// Shared status register types: status_t layout, CPU mode, and the interrupt sequencer states.
package reg_pkg;

    localparam int unsigned ALU_STATUS_W = 4;

    typedef enum logic {
        USER       = 1'b0,
        SUPERVISOR = 1'b1
    } cpu_mode_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_status_t;

    // Field order fixes the 6-bit image: {alu_status[3:0], imask, mode}
    typedef struct packed {
        alu_status_t alu_status;
        logic        imask;
        cpu_mode_e   mode;
    } status_t;

    localparam int unsigned STATUS_W = $bits(status_t);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        ACTIVE = 2'd2,
        EXIT   = 2'd3
    } irq_state_e;

endpackage

// File: rtl/irq_status_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set index wins; purely combinational.
module irq_prio_enc #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned W = $clog2(N);

    // Scan high to low so the last hit, the lowest index, is kept
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_status_ctrl.sv
// Interrupt entry/exit sequencer driving status_reg load ports.
// Build option: define IRQ_EDGE_EN for rising-edge request capture instead of level.
module irq_status_ctrl
    import reg_pkg::*;
#(
    parameter int unsigned N_IRQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IRQ-1:0]         irq,
    input  logic [N_IRQ-1:0]         irq_en,
    input  status_t                  status,
    input  logic                     boundary,
    input  logic                     reti,
    output logic                     int_req,
    output logic                     int_take,
    output logic [$clog2(N_IRQ)-1:0] int_vec,
    output logic                     busy,
    output logic                     status_ld,
    output status_t                  status_in,
    output logic                     ld_imask,
    output logic                     imask_in,
    output logic                     ld_mode,
    output cpu_mode_e                mode_in
);

    localparam int unsigned VEC_W = $clog2(N_IRQ);

    irq_state_e       state_q,   state_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    status_t          shadow_q,  shadow_d;
    logic [VEC_W-1:0] int_vec_q, int_vec_d;

    logic [N_IRQ-1:0] irq_set;
    logic [N_IRQ-1:0] sel;
    logic             sel_valid;
    logic [VEC_W-1:0] sel_idx;

`ifdef IRQ_EDGE_EN
    logic [N_IRQ-1:0] irq_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq;
        end
    end

    // A held line produces a single request
    assign irq_set = irq & ~irq_q & irq_en;
`else
    assign irq_set = irq & irq_en;
`endif

    // Disabled sources keep their pending bit but cannot be selected
    assign sel = pending_q & irq_en;

    irq_prio_enc #(
        .N (N_IRQ)
    ) u_prio_enc (
        .req   (sel),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    assign int_req   = (state_q == IDLE) & sel_valid & ~status.imask;
    assign busy      = (state_q != IDLE);
    assign int_vec   = int_vec_q;
    assign status_in = shadow_q;

    // Clear the serviced bit first so a same-cycle set survives
    always_comb begin
        pending_d = pending_q;
        if (state_q == ENTER) begin
            for (int unsigned i = 0; i < N_IRQ; i++) begin
                if (VEC_W'(i) == int_vec_q) begin
                    pending_d[i] = 1'b0;
                end
            end
        end
        pending_d = pending_d | irq_set;
    end

    always_comb begin
        state_d   = state_q;
        int_vec_d = int_vec_q;
        shadow_d  = shadow_q;
        int_take  = 1'b0;
        ld_mode   = 1'b0;
        mode_in   = USER;
        ld_imask  = 1'b0;
        imask_in  = 1'b0;
        status_ld = 1'b0;
        case (state_q)
            IDLE: begin
                if (int_req && boundary) begin
                    state_d   = ENTER;
                    int_vec_d = sel_idx;
                end
            end
            ENTER: begin
                shadow_d = status;
                int_take = 1'b1;
                ld_mode  = 1'b1;
                mode_in  = SUPERVISOR;
                ld_imask = 1'b1;
                imask_in = 1'b1;
                state_d  = ACTIVE;
            end
            ACTIVE: begin
                if (reti) begin
                    state_d = EXIT;
                end
            end
            EXIT: begin
                status_ld = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            shadow_q  <= '0;
            int_vec_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            int_vec_q <= int_vec_d;
        end
    end

endmodule

// File: tb/tb_irq_status_ctrl.sv
// Scoreboard bench for irq_status_ctrl with a behavioural status_reg alongside.
module tb_irq_status_ctrl;
    import reg_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] irq;
    logic [3:0] irq_en;
    status_t    st;
    logic       boundary;
    logic       reti;
    logic       int_req;
    logic       int_take;
    logic [1:0] int_vec;
    logic       busy;
    logic       status_ld;
    status_t    status_in;
    logic       ld_imask;
    logic       imask_in;
    logic       ld_mode;
    cpu_mode_e  mode_in;

    logic       sr_rst_n;
    logic       bld;
    status_t    bval;

    typedef struct {
        bit         is_exit;
        logic [1:0] vec;
        status_t    st;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    irq_status_ctrl #(.N_IRQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .irq_en    (irq_en),
        .status    (st),
        .boundary  (boundary),
        .reti      (reti),
        .int_req   (int_req),
        .int_take  (int_take),
        .int_vec   (int_vec),
        .busy      (busy),
        .status_ld (status_ld),
        .status_in (status_in),
        .ld_imask  (ld_imask),
        .imask_in  (imask_in),
        .ld_mode   (ld_mode),
        .mode_in   (mode_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural status_reg with its own reset and a bench load port
    always_ff @(posedge clk or negedge sr_rst_n) begin
        if (!sr_rst_n) begin
            st <= '0;
        end else if (bld) begin
            st <= bval;
        end else if (status_ld) begin
            st <= status_in;
        end else begin
            if (ld_mode)  st.mode  <= mode_in;
            if (ld_imask) st.imask <= imask_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic status_t mk_st(input logic [3:0] a, input logic im, input logic md);
        return status_t'({a, im, md});
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_status(input status_t s);
        bld  = 1'b1;
        bval = s;
        tick();
        bld  = 1'b0;
    endtask

    task automatic enter(input logic [1:0] vec, input status_t s);
        exp_q.push_back('{is_exit: 1'b0, vec: vec, st: s});
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        tick();
        @(negedge clk);
        chk("busy_active", 32'(busy), 32'd1);
        chk("req_active", 32'(int_req), 32'd0);
    endtask

    task automatic leave(input status_t s, input logic [3:0] irq_pulse);
        exp_q.push_back('{is_exit: 1'b1, vec: 2'd0, st: s});
        reti = 1'b1;
        irq  = irq | irq_pulse;
        tick();
        reti = 1'b0;
        irq  = irq & ~irq_pulse;
        tick();
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Output monitor: every strobe must match the front of the expectation queue
    always @(negedge clk) begin : mon
        exp_t e;
        if (int_take) begin
            if (exp_q.size() == 0 || exp_q[0].is_exit) begin
                chk("unexpected_take", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("take_vec", 32'(int_vec), 32'(e.vec));
                chk("take_ld_mode", 32'(ld_mode), 32'd1);
                chk("take_mode_in", 32'(mode_in), 32'(SUPERVISOR));
                chk("take_ld_imask", 32'(ld_imask), 32'd1);
                chk("take_imask_in", 32'(imask_in), 32'd1);
                chk("take_no_ld", 32'(status_ld), 32'd0);
            end
        end
        if (status_ld) begin
            if (exp_q.size() == 0 || !exp_q[0].is_exit) begin
                chk("unexpected_exit", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("exit_status_in", 32'(status_in), 32'(e.st));
                chk("exit_no_mode", 32'(ld_mode), 32'd0);
                chk("exit_no_imask", 32'(ld_imask), 32'd0);
                chk("exit_busy", 32'(busy), 32'd1);
            end
        end
    end

    initial begin
        rst      = 1'b0;
        sr_rst_n = 1'b0;
        irq      = '0;
        irq_en   = '0;
        boundary = 1'b0;
        reti     = 1'b0;
        bld      = 1'b0;
        bval     = '0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_int_req", 32'(int_req), 32'd0);
        chk("rst_int_take", 32'(int_take), 32'd0);
        chk("rst_int_vec", 32'(int_vec), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_status_ld", 32'(status_ld), 32'd0);
        chk("rst_status_in", 32'(status_in), 32'd0);
        chk("rst_ld_imask", 32'(ld_imask), 32'd0);
        chk("rst_imask_in", 32'(imask_in), 32'd0);
        chk("rst_ld_mode", 32'(ld_mode), 32'd0);
        chk("rst_mode_in", 32'(mode_in), 32'd0);
        tick();
        rst      = 1'b1;
        sr_rst_n = 1'b1;

        // Basic entry and exit on source 2
        irq_en = 4'hF;
        load_status(mk_st(4'b1010, 1'b0, 1'b0));
        irq = 4'b0100;
        tick();
        irq = 4'b0000;
        @(negedge clk);
        chk("req_src2", 32'(int_req), 32'd1);
        enter(2'd2, mk_st(4'b1010, 1'b0, 1'b0));
        chk("st_after_entry", 32'(st), 32'(mk_st(4'b1010, 1'b1, 1'b1)));
        leave(mk_st(4'b1010, 1'b0, 1'b0), 4'b0000);
        chk("st_after_exit", 32'(st), 32'(mk_st(4'b1010, 1'b0, 1'b0)));

        // Priority, plus an irq arriving together with reti
        irq = 4'b1010;
        tick();
        irq = 4'b0000;
        enter(2'd1, mk_st(4'b1010, 1'b0, 1'b0));
        leave(mk_st(4'b1010, 1'b0, 1'b0), 4'b0000);
        chk("req_src3_left", 32'(int_req), 32'd1);
        enter(2'd3, mk_st(4'b1010, 1'b0, 1'b0));
        leave(mk_st(4'b1010, 1'b0, 1'b0), 4'b0100);
        chk("req_latched_with_reti", 32'(int_req), 32'd1);
        enter(2'd2, mk_st(4'b1010, 1'b0, 1'b0));
        leave(mk_st(4'b1010, 1'b0, 1'b0), 4'b0000);
        chk("req_all_done", 32'(int_req), 32'd0);

        // Mask holds off entry while the request stays pending
        load_status(mk_st(4'b0000, 1'b1, 1'b0));
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        @(negedge clk);
        chk("mask_req", 32'(int_req), 32'd0);
        boundary = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("mask_hold_req", 32'(int_req), 32'd0);
            chk("mask_hold_take", 32'(int_take), 32'd0);
        end
        boundary = 1'b0;
        load_status(mk_st(4'b0000, 1'b0, 1'b0));
        @(negedge clk);
        chk("unmask_req", 32'(int_req), 32'd1);
        enter(2'd0, mk_st(4'b0000, 1'b0, 1'b0));
        leave(mk_st(4'b0000, 1'b0, 1'b0), 4'b0000);

        // Per-source enable
        irq_en = 4'b1110;
        irq    = 4'b0001;
        tick();
        @(negedge clk);
        chk("en_off_req", 32'(int_req), 32'd0);
        irq_en = 4'hF;
        #1;
        chk("en_same_cycle_req", 32'(int_req), 32'd0);
        tick();
        irq = 4'b0000;
        @(negedge clk);
`ifdef IRQ_EDGE_EN
        chk("en_held_no_edge", 32'(int_req), 32'd0);
`else
        chk("en_on_req", 32'(int_req), 32'd1);
        enter(2'd0, mk_st(4'b0000, 1'b0, 1'b0));
        leave(mk_st(4'b0000, 1'b0, 1'b0), 4'b0000);
`endif

        // Stray reti in IDLE
        reti = 1'b1;
        tick();
        reti = 1'b0;
        @(negedge clk);
        chk("stray_reti_ld", 32'(status_ld), 32'd0);
        chk("stray_reti_busy", 32'(busy), 32'd0);

        // Reset in the middle of a handler
        irq = 4'b1000;
        tick();
        irq = 4'b0000;
        enter(2'd3, mk_st(4'b0000, 1'b0, 1'b0));
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_vec", 32'(int_vec), 32'd0);
        chk("midrst_status_in", 32'(status_in), 32'd0);
        chk("midrst_take", 32'(int_take), 32'd0);
        tick();
        rst  = 1'b1;
        reti = 1'b1;
        tick();
        reti = 1'b0;
        @(negedge clk);
        chk("midrst_reti_ld", 32'(status_ld), 32'd0);
        chk("midrst_reti_busy", 32'(busy), 32'd0);
        load_status(mk_st(4'b0000, 1'b0, 1'b0));

`ifdef IRQ_EDGE_EN
        // Held level retriggers nothing after the handler
        irq = 4'b0001;
        tick();
        @(negedge clk);
        chk("edge_req", 32'(int_req), 32'd1);
        enter(2'd0, mk_st(4'b0000, 1'b0, 1'b0));
        leave(mk_st(4'b0000, 1'b0, 1'b0), 4'b0000);
        boundary = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("edge_no_reentry", 32'(int_take), 32'd0);
        end
        boundary = 1'b0;
        irq = 4'b0000;
`endif

        repeat (3) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
